// File: rtl/edge_pkg.sv
// Shared types for the edge-detection pipeline (gradient, NMS, hysteresis).
package edge_pkg;
  localparam int MAG_W = 8;

  typedef logic [MAG_W-1:0] mag_t;

  typedef enum logic [1:0] {
    ANG_H    = 2'd0,
    ANG_D45  = 2'd1,
    ANG_V    = 2'd2,
    ANG_D135 = 2'd3
  } angle_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } nms_state_t;
endpackage

// File: rtl/nms_line_buffer.sv
// One-row delay line of packed {mag, angle} pixels; advances only when en is high.
module nms_line_buffer
  import edge_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] taps_p0 [DEPTH];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) taps_p0[i] <= '0;
    end else if (en) begin
      taps_p0[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps_p0[i] <= taps_p0[i-1];
    end
  end

  assign dout = taps_p0[DEPTH-1];
endmodule

// File: rtl/non_max_suppress.sv
// Canny non-maximum suppression over a 3x3 raster window built from two line buffers.
// Optional magnitude floor (low_thresh port) when NMS_LOW_THRESH_EN is defined.
module non_max_suppress
  import edge_pkg::*;
#(
  parameter int PRECISION = 8,
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic [PRECISION-1:0] in_mag,
  input  logic [1:0]           in_angle,
`ifdef NMS_LOW_THRESH_EN
  input  logic [PRECISION-1:0] low_thresh,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PRECISION-1:0] out_mag,
  output logic                 out_eof
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int FW = $clog2(WIDTH + 1);
  localparam int PW = PRECISION + 2;
  localparam logic [CW-1:0] LAST_COL   = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(HEIGHT - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(WIDTH);

  nms_state_t state, state_d;
  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic [FW-1:0] flush_cnt;
  logic accept, out_free, restart, shift_en, last_in, emit_run, emit_flush, border;
  logic [PW-1:0] in_pix, lb1_out, lb2_out;
  logic [PRECISION-1:0] win_mag_p0 [3][3];
  logic [1:0]           win_ang_p0 [3][3];
  logic [PRECISION-1:0] nxt_mag [3][3];
  logic [1:0]           nxt_ang [3][3];
  logic [PRECISION-1:0] a_mag, b_mag, floor_mag, nms_mag;

  function automatic logic [PRECISION-1:0] nms_pick(input logic [PRECISION-1:0] mag,
                                                    input logic [PRECISION-1:0] a,
                                                    input logic [PRECISION-1:0] b,
                                                    input logic [PRECISION-1:0] flr);
    return (mag > a && mag >= b && mag >= flr) ? mag : '0;
  endfunction

`ifdef NMS_LOW_THRESH_EN
  assign floor_mag = low_thresh;
`else
  assign floor_mag = '0;
`endif

  assign out_free   = !out_valid || out_ready;
  assign in_ready   = (state != FLUSH) && out_free;
  assign accept     = in_valid && in_ready;
  assign restart    = accept && in_sof;
  assign shift_en   = accept && (in_sof || state != IDLE);
  assign last_in    = (in_col == LAST_COL) && (in_row == LAST_ROW);
  assign emit_run   = accept && !in_sof && (state == RUN);
  assign emit_flush = (state == FLUSH) && out_free;
  // Centre is pixel k-WIDTH-1; in_col 0/1 map to output cols WIDTH-1/0, in_row 1 to output row 0.
  assign border     = (in_col <= CW'(1)) || (in_row == RW'(1));
  assign in_pix     = {in_mag, in_angle};

  nms_line_buffer #(.DEPTH(WIDTH), .DATA_W(PW)) u_lb_r1 (
    .clk(clk), .n_rst(n_rst), .en(shift_en), .din(in_pix), .dout(lb1_out)
  );
  nms_line_buffer #(.DEPTH(WIDTH), .DATA_W(PW)) u_lb_r2 (
    .clk(clk), .n_rst(n_rst), .en(shift_en), .din(lb1_out), .dout(lb2_out)
  );

  // Stage p0 -> comparator: evaluate on the window as it looks after this accept's shift
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nxt_mag[r][0] = win_mag_p0[r][1];
      nxt_ang[r][0] = win_ang_p0[r][1];
      nxt_mag[r][1] = win_mag_p0[r][2];
      nxt_ang[r][1] = win_ang_p0[r][2];
    end
    nxt_mag[0][2] = lb2_out[PW-1:2];
    nxt_ang[0][2] = lb2_out[1:0];
    nxt_mag[1][2] = lb1_out[PW-1:2];
    nxt_ang[1][2] = lb1_out[1:0];
    nxt_mag[2][2] = in_mag;
    nxt_ang[2][2] = in_angle;
  end

  always_comb begin
    a_mag = nxt_mag[1][0];
    b_mag = nxt_mag[1][2];
    case (angle_t'(nxt_ang[1][1]))
      ANG_H:    begin a_mag = nxt_mag[1][0]; b_mag = nxt_mag[1][2]; end
      ANG_D45:  begin a_mag = nxt_mag[0][2]; b_mag = nxt_mag[2][0]; end
      ANG_V:    begin a_mag = nxt_mag[0][1]; b_mag = nxt_mag[2][1]; end
      ANG_D135: begin a_mag = nxt_mag[0][0]; b_mag = nxt_mag[2][2]; end
    endcase
    nms_mag = border ? '0 : nms_pick(nxt_mag[1][1], a_mag, b_mag, floor_mag);
  end

  always_comb begin
    state_d = state;
    if (restart) begin
      state_d = FILL;
    end else begin
      case (state)
        FILL:    if (accept && in_col == '0 && in_row == RW'(1)) state_d = RUN;
        RUN:     if (accept && last_in) state_d = FLUSH;
        FLUSH:   if (emit_flush && flush_cnt == FLUSH_LAST) state_d = IDLE;
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      in_col    <= '0;
      in_row    <= '0;
      flush_cnt <= '0;
    end else begin
      if (restart) begin
        in_col <= CW'(1);
        in_row <= '0;
      end else if (shift_en) begin
        if (in_col == LAST_COL) begin
          in_col <= '0;
          in_row <= last_in ? '0 : in_row + RW'(1);
        end else begin
          in_col <= in_col + CW'(1);
        end
      end
      if (state != FLUSH)  flush_cnt <= '0;
      else if (emit_flush) flush_cnt <= flush_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_mag_p0[r][c] <= '0;
          win_ang_p0[r][c] <= '0;
        end
      end
    end else if (shift_en) begin
      win_mag_p0 <= nxt_mag;
      win_ang_p0 <= nxt_ang;
    end
  end

  // Stage p1: registered output, held while downstream stalls
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_eof   <= 1'b0;
    end else if (restart) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_eof   <= 1'b0;
    end else if (emit_run) begin
      out_valid <= 1'b1;
      out_mag   <= nms_mag;
      out_eof   <= 1'b0;
    end else if (emit_flush) begin
      out_valid <= 1'b1;
      out_mag   <= '0;
      out_eof   <= (flush_cnt == FLUSH_LAST);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_non_max_suppress.sv
// Randomised bench for non_max_suppress (WIDTH=HEIGHT=4) against a frame-level NMS model.
module tb_non_max_suppress;
  localparam int P = 8;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic [P-1:0] in_mag = '0;
  logic [1:0] in_angle = '0;
  logic in_ready, out_valid, out_eof;
  logic [P-1:0] out_mag;
`ifdef NMS_LOW_THRESH_EN
  logic [P-1:0] low_thresh = '0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int thr = 0;
  logic [P-1:0] img_mag [N];
  logic [1:0]   img_ang [N];
  logic [P-1:0] got_mag [$];
  bit           got_eof [$];
  bit in_acc = 1'b0, hold_prev = 1'b0;
  logic [P-1:0] prev_mag = '0;
  logic prev_eof = 1'b0;

  always #5 clk = ~clk;

  non_max_suppress #(.PRECISION(P), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_mag(in_mag), .in_angle(in_angle),
`ifdef NMS_LOW_THRESH_EN
    .low_thresh(low_thresh),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mag(out_mag), .out_eof(out_eof)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_thr(input int t);
    thr = t;
`ifdef NMS_LOW_THRESH_EN
    low_thresh = P'(t);
`endif
  endtask

  // Sample on the falling edge, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (n_rst) begin
      if (hold_prev) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_mag", out_mag, prev_mag);
        check_val("hold_eof", out_eof, prev_eof);
      end
      if (out_valid && !out_ready) check_val("stall_in_ready", in_ready, 0);
      hold_prev = out_valid && !out_ready;
      prev_mag  = out_mag;
      prev_eof  = out_eof;
      if (out_valid && out_ready) begin
        got_mag.push_back(out_mag);
        got_eof.push_back(out_eof);
      end
      in_acc = in_valid && in_ready;
    end else begin
      in_acc = 1'b0;
      hold_prev = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    if (mode == 1) return ($urandom_range(0, 99) < 60);
    if (mode == 2) return !(cyc >= 10 && cyc < 15);
    return 1'b1;
  endfunction

  task automatic send(input int n, input int gap_pct, input int mode);
    int p = 0;
    int cyc = 0;
    while (p < n && cyc < 2000) begin
      in_valid  = ($urandom_range(0, 99) >= gap_pct);
      in_sof    = (p == 0);
      in_mag    = img_mag[p];
      in_angle  = img_ang[p];
      out_ready = pick_ready(mode, cyc);
      tick();
      cyc++;
      if (in_acc) p++;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (p < n) check_val("send_timeout", p, n);
  endtask

  task automatic drain(input int mode);
    int cyc = 0;
    while (!(got_eof.size() > 0 && got_eof[got_eof.size()-1]) && cyc < 300) begin
      out_ready = pick_ready(mode, 1000);
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    if (cyc >= 300) check_val("drain_timeout", 0, 1);
  endtask

  function automatic int px(input int r, input int c);
    return int'(img_mag[r*W + c]);
  endfunction

  // Reference: direct application of the suppression rule to the whole frame.
  task automatic compare_frame(input string tag);
    int exp_mag [N];
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int m, a, b;
        m = px(r, c);
        a = 0;
        b = 0;
        if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
          exp_mag[r*W+c] = 0;
        end else begin
          case (img_ang[r*W+c])
            2'd0:    begin a = px(r, c-1);   b = px(r, c+1);   end
            2'd1:    begin a = px(r-1, c+1); b = px(r+1, c-1); end
            2'd2:    begin a = px(r-1, c);   b = px(r+1, c);   end
            default: begin a = px(r-1, c-1); b = px(r+1, c+1); end
          endcase
          exp_mag[r*W+c] = (m > a && m >= b && m >= thr) ? m : 0;
        end
      end
    end
    check_val({tag, "_count"}, got_mag.size(), N);
    for (int i = 0; i < N && i < got_mag.size(); i++) begin
      check_val($sformatf("%s_mag%0d", tag, i), got_mag[i], exp_mag[i]);
      check_val($sformatf("%s_eof%0d", tag, i), got_eof[i], (i == N-1));
    end
    got_mag.delete();
    got_eof.delete();
  endtask

  task automatic run_frame(input string tag, input int gap_pct, input int mode);
    send(N, gap_pct, mode);
    drain(mode == 2 ? 0 : mode);
    compare_frame(tag);
  endtask

  task automatic img_ridge();
    for (int i = 0; i < N; i++) begin
      img_mag[i] = (i % W == 1) ? P'(50) : P'(10);
      img_ang[i] = 2'd0;
    end
  endtask

  task automatic img_random();
    for (int i = 0; i < N; i++) begin
      img_mag[i] = P'($urandom_range(0, 15));
      img_ang[i] = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic img_diag(input int ne, input int sw);
    for (int i = 0; i < N; i++) begin
      img_mag[i] = '0;
      img_ang[i] = 2'd0;
    end
    img_mag[1*W+1] = P'(40);
    img_ang[1*W+1] = 2'd1;
    img_mag[0*W+2] = P'(ne);
    img_mag[2*W+0] = P'(sw);
  endtask

  initial begin
    repeat (3) tick();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_mag", out_mag, 0);
    check_val("rst_out_eof", out_eof, 0);
    n_rst = 1'b1;
    tick();
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_idle_valid", out_valid, 0);

    img_ridge();
    run_frame("ridge", 0, 0);

    for (int i = 0; i < N; i++) begin
      img_mag[i] = P'(20);
      img_ang[i] = 2'd2;
    end
    run_frame("flat", 0, 0);

    img_diag(30, 39);
    run_frame("diag", 0, 0);
    img_diag(30, 40);
    run_frame("diag_sw_tie", 0, 0);
    img_diag(40, 39);
    run_frame("diag_ne_tie", 0, 0);

    img_ridge();
    run_frame("stall_ridge", 0, 2);
    img_random();
    run_frame("stall_rand", 0, 2);

    for (int f = 0; f < 8; f++) begin
      img_random();
      run_frame($sformatf("rand%0d", f), 30, 1);
    end

    // Restart: seven pixels of one frame, then a fresh frame with in_sof.
    img_random();
    send(7, 0, 0);
    img_random();
    send(N, 0, 0);
    drain(0);
    check_val("restart_old_count", got_mag.size() >= 2, 1);
    if (got_mag.size() >= 2) begin
      check_val("restart_old0", got_mag.pop_front(), 0);
      check_val("restart_old0_eof", got_eof.pop_front(), 0);
      check_val("restart_old1", got_mag.pop_front(), 0);
      check_val("restart_old1_eof", got_eof.pop_front(), 0);
    end
    compare_frame("restart");

    // Asynchronous reset during the flush phase.
    img_ridge();
    send(N, 0, 0);
    tick();
    tick();
    check_val("flush_valid_before_rst", out_valid, 1);
    n_rst = 1'b0;
    #1;
    check_val("rst_flush_valid", out_valid, 0);
    check_val("rst_flush_eof", out_eof, 0);
    check_val("rst_flush_mag", out_mag, 0);
    tick();
    tick();
    n_rst = 1'b1;
    got_mag.delete();
    got_eof.delete();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_sof   = 1'b0;
      in_mag   = P'($urandom_range(0, 255));
      in_angle = 2'($urandom_range(0, 3));
      tick();
      check_val($sformatf("drop_ready%0d", i), in_ready, 1);
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check_val("drop_no_output", got_mag.size(), 0);
    check_val("drop_valid", out_valid, 0);
    img_random();
    run_frame("after_rst", 0, 0);

`ifdef NMS_LOW_THRESH_EN
    img_ridge();
    set_thr(60);
    run_frame("thr60", 0, 0);
    set_thr(50);
    run_frame("thr50", 0, 0);
    for (int f = 0; f < 3; f++) begin
      img_random();
      set_thr($urandom_range(0, 12));
      run_frame($sformatf("thr_rand%0d", f), 20, 1);
    end
    set_thr(0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
